// File: rtl/tl_egress.sv
// tl_egress: per-VC ejection buffers feeding one AXI-stream port.
// Packets are granted round-robin and locked until TAIL; each pop returns a credit.
module tl_egress #(
  parameter int AXI_D_WIDTH = 24,
  parameter int D_WIDTH     = 32,
  parameter int VID_BITS    = 6,
  parameter int TYPE_BITS   = 2,
  parameter int DEST_BITS   = 4,
  parameter int NUM_VC      = 4,
  parameter int BUF_DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [D_WIDTH-1:0]        flit_in,
  input  logic                      flit_valid,
  input  logic [$clog2(NUM_VC)-1:0] flit_vc,
  output logic [AXI_D_WIDTH-1:0]    out_tdata,
  output logic                      out_tvalid,
  output logic                      out_tlast,
  input  logic                      out_tready,
  output logic [DEST_BITS-1:0]      out_tuser,
  output logic                      cred_valid,
  output logic [$clog2(NUM_VC)-1:0] cred_vc,
  output logic                      err_overflow,
  output logic                      err_proto
);

  localparam int VW = $clog2(NUM_VC);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int TM = D_WIDTH - VID_BITS - 1;

  localparam logic [TYPE_BITS-1:0] T_HDR  = TYPE_BITS'(3);
  localparam logic [TYPE_BITS-1:0] T_TAIL = TYPE_BITS'(1);
  localparam logic [TYPE_BITS-1:0] T_CRED = TYPE_BITS'(0);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state, state_nx;

  logic [D_WIDTH-1:0] mem [NUM_VC][BUF_DEPTH];
  logic [PW-1:0]      wptr [NUM_VC];
  logic [PW-1:0]      rptr [NUM_VC];
  logic [CW-1:0]      cnt  [NUM_VC];

  logic [VW-1:0]        lock, last, grant, idx, sel;
  logic                 found, avail, pop, tvalid;
  logic                 hdr_pop, proto_drop;
  logic                 is_cred, full_in, wr;
  logic [D_WIDTH-1:0]   head;
  logic [TYPE_BITS-1:0] htype;
  logic [NUM_VC-1:0]    wr_hit, pop_hit;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search starts one past the last granted VC.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 1; i <= NUM_VC; i++) begin
      idx = VW'((int'(last) + i) % NUM_VC);
      if (!found && cnt[idx] != '0) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign sel   = (state == IDLE) ? grant : lock;
  assign head  = mem[sel][rptr[sel]];
  assign htype = head[TM -: TYPE_BITS];
  assign avail = cnt[sel] != '0;

  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    tvalid     = 1'b0;
    hdr_pop    = 1'b0;
    proto_drop = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          pop = 1'b1;
          if (htype == T_HDR) begin
            hdr_pop  = 1'b1;
            state_nx = STREAM;
          end else begin
            proto_drop = 1'b1;
          end
        end
      end
      STREAM: begin
        if (avail) begin
          if (htype == T_HDR) begin
            pop        = 1'b1;
            proto_drop = 1'b1;
          end else begin
            tvalid = 1'b1;
            if (out_tready) begin
              pop = 1'b1;
              if (htype == T_TAIL) state_nx = IDLE;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign out_tvalid = tvalid;
  assign out_tdata  = tvalid ? head[AXI_D_WIDTH-1:0] : '0;
  assign out_tlast  = tvalid && (htype == T_TAIL);

  // A full VC still accepts a write when it is popped in the same cycle.
  assign is_cred = flit_in[TM -: TYPE_BITS] == T_CRED;
  assign full_in = cnt[flit_vc] == CW'(BUF_DEPTH);
  assign wr      = flit_valid && !is_cred
                && (!full_in || (pop && sel == flit_vc));

  always_comb begin
    wr_hit  = '0;
    pop_hit = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_hit[v]  = wr && (flit_vc == VW'(v));
      pop_hit[v] = pop && (sel == VW'(v));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lock         <= '0;
      last         <= VW'(NUM_VC - 1);
      out_tuser    <= '0;
      cred_valid   <= 1'b0;
      cred_vc      <= '0;
      err_overflow <= 1'b0;
      err_proto    <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        wptr[v] <= '0;
        rptr[v] <= '0;
        cnt[v]  <= '0;
      end
    end else begin
      state      <= state_nx;
      cred_valid <= pop;
      cred_vc    <= pop ? sel : '0;
      if (hdr_pop) begin
        lock      <= sel;
        out_tuser <= head[16 +: DEST_BITS];
      end
      if (state == IDLE && found) last <= grant;
      if (flit_valid && !is_cred && !wr) err_overflow <= 1'b1;
      if (proto_drop || (flit_valid && is_cred)) err_proto <= 1'b1;
      for (int v = 0; v < NUM_VC; v++) begin
        if (wr_hit[v]) wptr[v] <= nxt(wptr[v]);
        if (pop_hit[v]) rptr[v] <= nxt(rptr[v]);
        if (wr_hit[v] && !pop_hit[v]) cnt[v] <= cnt[v] + 1'b1;
        else if (!wr_hit[v] && pop_hit[v]) cnt[v] <= cnt[v] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[flit_vc][wptr[flit_vc]] <= flit_in;
  end

endmodule

// File: tb/tb_tl_egress.sv
// tb_tl_egress: directed packet scenarios plus random traffic,
// scored against a queue-based packet model of the egress port.
module tb_tl_egress;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] flit_in = '0;
  logic        flit_valid = 1'b0;
  logic [1:0]  flit_vc = '0;
  logic [23:0] out_tdata;
  logic        out_tvalid, out_tlast;
  logic        out_tready = 1'b0;
  logic [3:0]  out_tuser;
  logic        cred_valid;
  logic [1:0]  cred_vc;
  logic        err_overflow, err_proto;

  tl_egress dut (
    .clk(clk), .rst(rst),
    .flit_in(flit_in), .flit_valid(flit_valid), .flit_vc(flit_vc),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid),
    .out_tlast(out_tlast), .out_tready(out_tready),
    .out_tuser(out_tuser),
    .cred_valid(cred_valid), .cred_vc(cred_vc),
    .err_overflow(err_overflow), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Packet-level model: one queue per VC, a lock, a round-robin pointer.
  logic [31:0] q [4][$];
  bit          m_stream;
  int          m_lock, m_last, m_cvc;
  logic [3:0]  m_tuser;
  bit          m_cv, m_eo, m_ep;

  logic [23:0] beat_log [$];
  logic [23:0] want [$];
  int          cred_cnt [4];

  task automatic model_reset();
    for (int v = 0; v < 4; v++) q[v].delete();
    m_stream = 0; m_lock = 0; m_last = 3; m_tuser = '0;
    m_cv = 0; m_cvc = 0; m_eo = 0; m_ep = 0;
  endtask

  task automatic model_clock(bit v, logic [31:0] f, int vc, bit rdy);
    bit popped = 0;
    int pv = 0;
    logic [31:0] h;
    if (!m_stream) begin
      for (int i = 1; i <= 4; i++) begin
        int c;
        c = (m_last + i) % 4;
        if (!popped && q[c].size() > 0) begin
          h = q[c].pop_front();
          popped = 1; pv = c; m_last = c;
          if (h[25:24] == 2'b11) begin
            m_tuser = h[19:16]; m_lock = c; m_stream = 1;
          end else m_ep = 1;
        end
      end
    end else if (q[m_lock].size() > 0) begin
      h = q[m_lock][0];
      if (h[25:24] == 2'b11) begin
        q[m_lock].delete(0);
        popped = 1; pv = m_lock; m_ep = 1;
      end else if (rdy) begin
        q[m_lock].delete(0);
        popped = 1; pv = m_lock;
        if (h[25:24] == 2'b01) m_stream = 0;
      end
    end
    if (v) begin
      if (f[25:24] == 2'b00) m_ep = 1;
      else if (q[vc].size() < 8) q[vc].push_back(f);
      else m_eo = 1;
    end
    m_cv = popped; m_cvc = pv;
  endtask

  task automatic step(bit v, logic [31:0] f, int vc, bit rdy, bit r);
    bit tv;
    logic [31:0] h;
    @(negedge clk);
    flit_valid = v; flit_in = f; flit_vc = 2'(vc);
    out_tready = rdy; rst = r;
    #1;
    tv = 0; h = '0;
    if (m_stream && q[m_lock].size() > 0) begin
      h = q[m_lock][0];
      tv = h[25:24] != 2'b11;
    end
    chk("tvalid", out_tvalid, tv);
    if (tv) begin
      chk("tdata", out_tdata, h[23:0]);
      chk("tlast", out_tlast, h[25:24] == 2'b01);
    end
    chk("tuser", out_tuser, m_tuser);
    chk("cred_valid", cred_valid, m_cv);
    if (m_cv) chk("cred_vc", cred_vc, m_cvc);
    chk("err_overflow", err_overflow, m_eo);
    chk("err_proto", err_proto, m_ep);
    if (out_tvalid && rdy && !r) beat_log.push_back(out_tdata);
    if (cred_valid) cred_cnt[cred_vc]++;
    @(posedge clk);
    if (r) model_reset();
    else model_clock(v, f, vc, rdy);
  endtask

  function automatic logic [31:0] mk(logic [1:0] t, logic [23:0] p);
    return {6'($urandom), t, p};
  endfunction

  function automatic logic [31:0] hdr(logic [3:0] d);
    return mk(2'b11, {4'($urandom), d, 16'($urandom)});
  endfunction

  task automatic send(int vc, logic [31:0] f);
    step(1, f, vc, 1, 0);
  endtask

  task automatic idle(int n, bit rdy);
    repeat (n) step(0, '0, 0, rdy, 0);
  endtask

  task automatic clear_logs();
    beat_log.delete();
    want.delete();
    for (int v = 0; v < 4; v++) cred_cnt[v] = 0;
  endtask

  task automatic check_beats(string tag);
    chk({tag, "_nbeats"}, beat_log.size(), want.size());
    foreach (want[i])
      chk(tag, (i < beat_log.size()) ? beat_log[i] : 24'hx, want[i]);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", out_tvalid, 0);
    chk("rst_tdata", out_tdata, 0);
    chk("rst_tlast", out_tlast, 0);
    chk("rst_tuser", out_tuser, 0);
    chk("rst_cred", {cred_valid, cred_vc}, 0);
    chk("rst_err", {err_overflow, err_proto}, 0);
    model_reset();

    // Single packet on VC1.
    clear_logs();
    send(1, hdr(4'd5));
    send(1, mk(2'b10, 24'hA1));
    send(1, mk(2'b10, 24'hA2));
    send(1, mk(2'b01, 24'hA3));
    idle(6, 1);
    want = '{24'hA1, 24'hA2, 24'hA3};
    check_beats("r22_beat");
    chk("r22_tuser", out_tuser, 4'd5);
    chk("r22_creds", cred_cnt[1], 4);

    // Flit-interleaved packets on VC0 and VC2 come out whole, VC0 first.
    clear_logs();
    send(0, hdr(4'd2));  send(2, hdr(4'd7));
    send(0, mk(2'b10, 24'hB1)); send(2, mk(2'b10, 24'hC1));
    send(0, mk(2'b10, 24'hB2)); send(2, mk(2'b10, 24'hC2));
    send(0, mk(2'b01, 24'hB3)); send(2, mk(2'b01, 24'hC3));
    idle(10, 1);
    want = '{24'hB1, 24'hB2, 24'hB3, 24'hC1, 24'hC2, 24'hC3};
    check_beats("r23_beat");
    chk("r23_tuser", out_tuser, 4'd7);

    // Five-cycle stall mid-packet holds the beat and returns no credit.
    clear_logs();
    send(0, hdr(4'd9));
    send(0, mk(2'b10, 24'hD1));
    send(0, mk(2'b10, 24'hD2));
    step(1, mk(2'b01, 24'hD3), 0, 0, 0);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("r24_hold", {out_tvalid, out_tlast, out_tdata}, {2'b10, 24'hD2});
      chk("r24_nocred", cred_valid, 0);
      step(0, '0, 0, 0, 0);
      #1;
    end
    chk("r24_hold", {out_tvalid, out_tlast, out_tdata}, {2'b10, 24'hD2});
    idle(4, 1);
    want = '{24'hD1, 24'hD2, 24'hD3};
    check_beats("r24_beat");

    // Nine flits into VC3 while the port is locked on empty VC0.
    clear_logs();
    send(0, hdr(4'd1));
    idle(2, 1);
    send(3, hdr(4'd3));
    for (int i = 0; i < 6; i++) send(3, mk(2'b10, 24'(8'hE0 + i)));
    send(3, mk(2'b01, 24'hEE));
    send(3, mk(2'b10, 24'hEF));
    #1;
    chk("r25_overflow", err_overflow, 1);
    send(0, mk(2'b01, 24'h0F));
    idle(14, 1);
    chk("r25_creds", cred_cnt[3], 8);
    want = '{24'h0F, 24'hE0, 24'hE1, 24'hE2, 24'hE3,
             24'hE4, 24'hE5, 24'hEE};
    check_beats("r25_beat");

    // Reset clears sticky flags; a stray BODY in IDLE is a protocol error.
    step(0, '0, 0, 1, 1);
    #1;
    chk("rst2_err", {err_overflow, err_proto}, 0);
    chk("rst2_tuser", out_tuser, 0);
    clear_logs();
    send(0, mk(2'b10, 24'h55));
    idle(2, 1);
    chk("r26_proto", err_proto, 1);
    chk("r26_cred", cred_cnt[0], 1);
    send(0, hdr(4'd6));
    send(0, mk(2'b10, 24'h61));
    send(0, mk(2'b01, 24'h62));
    idle(4, 1);
    want = '{24'h61, 24'h62};
    check_beats("r26_beat");
    chk("r26_tuser", out_tuser, 4'd6);

    // Reset after two beats of a four-beat packet.
    clear_logs();
    send(1, hdr(4'd8));
    send(1, mk(2'b10, 24'h71));
    send(1, mk(2'b10, 24'h72));
    send(1, mk(2'b10, 24'h73));
    chk("r27_pre", beat_log.size(), 2);
    step(1, mk(2'b01, 24'h74), 1, 1, 1);
    #1;
    chk("r27_tvalid", out_tvalid, 0);
    chk("r27_err", {err_overflow, err_proto}, 0);
    idle(3, 1);
    clear_logs();
    send(2, hdr(4'd4));
    send(2, mk(2'b10, 24'h81));
    send(2, mk(2'b01, 24'h82));
    idle(4, 1);
    want = '{24'h81, 24'h82};
    check_beats("r27_beat");
    chk("r27_creds", cred_cnt[2], 3);

    // Random traffic scored cycle by cycle.
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [1:0] t;
      r = int'($urandom_range(0, 99));
      t = (r < 3) ? 2'b00 : (r < 18) ? 2'b11 : (r < 33) ? 2'b01 : 2'b10;
      step($urandom_range(0, 1) == 1, mk(t, 24'($urandom)),
           int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 499) == 0);
    end
    idle(40, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tl_egress.md
TL_EGRESS -- requirements
Module: tl_egress

Interface
REQ-001 Parameters (name, default, meaning):
- AXI_D_WIDTH, 24, AXI stream data width.
- D_WIDTH, 32, flit width.
- VID_BITS, 6, VC id field width.
- TYPE_BITS, 2, flit type field width.
- DEST_BITS, 4, destination field width.
- NUM_VC, 4, ejection VCs.
- BUF_DEPTH, 8, flits per VC buffer.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- flit_in, in, D_WIDTH, flit from router ejection port.
- flit_valid, in, 1, flit_in valid this cycle.
- flit_vc, in, $clog2(NUM_VC), target VC of flit_in.
- out_tdata, out, AXI_D_WIDTH, AXI stream data.
- out_tvalid, out, 1, AXI valid.
- out_tlast, out, 1, last beat of packet.
- out_tready, in, 1, AXI ready.
- out_tuser, out, DEST_BITS, destination captured from header.
- cred_valid, out, 1, one-credit return pulse.
- cred_vc, out, $clog2(NUM_VC), VC whose credit is returned.
- err_overflow, out, 1, sticky: flit dropped on full VC.
- err_proto, out, 1, sticky: illegal flit type or sequence.

Function
REQ-004 Flit fields:
- [31:26] VID; [25:24] type (11 HDR, 10 BODY, 01 TAIL, 00 CRED); [23:0] payload.
- HDR payload [19:16] = dest; remaining HDR payload bits are ignored.
- BODY/TAIL payload is the AXI data beat.
REQ-005 Each VC has a BUF_DEPTH-entry FIFO. flit_valid writes flit_in to FIFO[flit_vc]; the flit is visible at the FIFO head the next cycle.
REQ-006 A flit of type CRED is not buffered and returns no credit; it sets err_proto.
REQ-007 Write to a full FIFO: flit dropped, err_overflow set. Exception: a same-cycle pop from that VC frees a slot, and the write is then accepted.
REQ-008 Output FSM states: IDLE and STREAM; lock register holds the granted VC.
REQ-009 IDLE arbitration:
- Round-robin over VCs whose FIFO is non-empty.
- Search starts at (last grant + 1) mod NUM_VC.
REQ-010 IDLE, granted head is HDR:
- Pop the header and load out_tuser from its dest.
- Lock the VC and go to STREAM next cycle.
- out_tvalid = 0 throughout IDLE.
REQ-011 IDLE, granted head is not HDR: pop and drop it, set err_proto, stay IDLE.
REQ-012 STREAM, locked FIFO non-empty, head BODY/TAIL:
- out_tvalid = 1; out_tdata = head[23:0].
- out_tlast = 1 iff head is TAIL.
- Head and outputs hold stable until out_tready.
REQ-013 STREAM handshake (out_tvalid & out_tready) pops the head. A TAIL handshake returns the FSM to IDLE; otherwise it stays in STREAM.
REQ-014 STREAM, head is HDR: pop and drop it, set err_proto, stay in STREAM, out_tvalid = 0 that cycle.
REQ-015 STREAM, locked FIFO empty: out_tvalid = 0, no other VC is served, and the FSM waits.
REQ-016 At most one pop occurs per cycle, and every pop returns one credit:
- cred_valid = 1 and cred_vc = popped VC in the cycle after the pop.
- Dropped-on-full flits return no credit.
REQ-017 Throughput:
- One beat per cycle while ready and data are available.
- Header pop costs one cycle (IDLE).
- First body beat is no earlier than 2 cycles after the header is written.
REQ-018 out_tuser holds its value from the header pop until the next header pop.
REQ-019 Occupancy counters are $clog2(BUF_DEPTH+1) bits and never exceed BUF_DEPTH. FIFO pointers wrap modulo BUF_DEPTH.

Reset
REQ-020 rst in any cycle, including mid-packet:
- All FIFOs empty, FSM to IDLE, round-robin pointer such that VC0 is granted first.
- out_tvalid = 0, out_tlast = 0, out_tdata = 0, out_tuser = 0.
- cred_valid = 0, cred_vc = 0, err_overflow = 0, err_proto = 0.
REQ-021 Flits presented during rst are discarded; no credits are returned for flits buffered before reset.

Verification
REQ-022 VC1 receives HDR(dest=5), BODY 0xA1, BODY 0xA2, TAIL 0xA3, with out_tready=1 -> beats A1, A2, A3 with tlast on A3 only, out_tuser=5, four cred_valid pulses with cred_vc=1.
REQ-023 Packets interleaved flit-by-flit on VC0 and VC2 -> VC0 packet is output complete, then VC2 packet; no beat interleaving on the AXI side.
REQ-024 out_tready held 0 for 5 cycles mid-packet -> out_tdata and out_tlast stable; no pops and no credits during the stall.
REQ-025 Nine flits to VC3 with no drain (BUF_DEPTH=8) -> 9th flit dropped, err_overflow=1, and exactly 8 credits returned after draining.
REQ-026 BODY as first flit on VC0 in IDLE -> dropped, err_proto=1, cred_valid with cred_vc=0; a following HDR packet on VC0 is output normally.
REQ-027 rst asserted during a 4-beat packet after 2 beats -> the next cycle out_tvalid=0, all FIFOs empty, error flags 0; a fresh packet afterwards is output correctly.
